// File: rtl/atm_pkg.sv
// Shared constants, debounce state encoding and amount arithmetic for the ATM keypad.
package atm_pkg;

  localparam int unsigned DEB_CYC_DEF = 4;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_ERASE = 4'hB;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'b0001,
    ST_DB_PRESS   = 4'b0010,
    ST_PRESSED    = 4'b0100,
    ST_DB_RELEASE = 4'b1000
  } deb_state_e;

  // m*10 + d in 36 bits so that overflow past 32 bits is visible in the top nibble
  function automatic logic [35:0] mul10_add(input logic [31:0] m, input logic [3:0] d);
    logic [35:0] w;
    w = {4'b0000, m};
    return (w << 3) + (w << 1) + {32'd0, d};
  endfunction

  function automatic logic is_digit(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_key_debounce.sv
// Debounces a raw keypad level into a single registered accept pulse with the captured code.
// Accept pulse appears DEB_CYC-1 cycles after the first sampling edge that saw the key down.
module atm_key_debounce
  import atm_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic       accept_o,
  output logic [3:0] code_o
);

  localparam logic [7:0] DEB_LIM = DEB_CYC[7:0];

  deb_state_e state_q;
  logic [7:0] cnt_q;
  logic [3:0] code_q;
  logic       accept_q;
  logic [7:0] cnt_inc;

  assign cnt_inc  = cnt_q + 8'd1;
  assign accept_o = accept_q;
  assign code_o   = code_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      code_q   <= 4'd0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_valid_i) begin
            code_q <= key_code_i;
            cnt_q  <= 8'd1;
            if (DEB_LIM == 8'd1) begin
              state_q  <= ST_PRESSED;
              accept_q <= 1'b1;
            end else begin
              state_q <= ST_DB_PRESS;
            end
          end
        end
        ST_DB_PRESS: begin
          // a changed code while still bouncing counts as a fresh, unaccepted press
          if (key_valid_i && (key_code_i == code_q)) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == DEB_LIM) begin
              state_q  <= ST_PRESSED;
              accept_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end
        end
        ST_PRESSED: begin
          if (!key_valid_i) begin
            cnt_q   <= 8'd1;
            state_q <= (DEB_LIM == 8'd1) ? ST_IDLE : ST_DB_RELEASE;
          end
        end
        ST_DB_RELEASE: begin
          if (key_valid_i) begin
            state_q <= ST_PRESSED;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == DEB_LIM) begin
              state_q <= ST_IDLE;
              cnt_q   <= 8'd0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/atm_keypad.sv
// ATM keypad front end: debounce, PIN digit / ENTER / ERASE decode, saturating decimal amount entry.
// Strobes are registered and rise DEB_CYC cycles after the first edge that sampled the key down.
module atm_keypad
  import atm_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        MODO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        ENTER_PIN,
  output logic        ERASE_PIN,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        DESBORDE
);

  logic        accept;
  logic [3:0]  acc_code;

  logic        modo_q;
  logic [3:0]  digito_q, digito_d;
  logic [31:0] monto_q, monto_d;
  logic        desborde_q, desborde_d;
  logic        dstb_q, dstb_d;
  logic        enter_q, enter_d;
  logic        erase_q, erase_d;
  logic        mstb_q, mstb_d;

  logic        mode_chg;
  logic [31:0] base;
  logic [35:0] prod;

  atm_key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk         (clk),
    .reset       (reset),
    .key_valid_i (KEY_VALID),
    .key_code_i  (KEY_CODE),
    .accept_o    (accept),
    .code_o      (acc_code)
  );

  always_comb begin
    mode_chg   = (MODO != modo_q);
    // a mode change in the acceptance cycle means the key works on a cleared amount
    base       = mode_chg ? 32'd0 : monto_q;
    prod       = mul10_add(base, acc_code);
    digito_d   = digito_q;
    monto_d    = base;
    desborde_d = mode_chg ? 1'b0 : desborde_q;
    dstb_d     = 1'b0;
    enter_d    = 1'b0;
    erase_d    = 1'b0;
    mstb_d     = 1'b0;
    if (accept) begin
      if (acc_code == KEY_ENTER) begin
        enter_d = 1'b1;
      end else if (acc_code == KEY_ERASE) begin
        if (MODO) begin
          monto_d    = 32'd0;
          desborde_d = 1'b0;
          mstb_d     = 1'b1;
        end else begin
          erase_d = 1'b1;
        end
      end else if (is_digit(acc_code)) begin
        if (MODO) begin
          mstb_d = 1'b1;
          if (prod[35:32] != 4'd0) begin
            monto_d    = 32'hFFFF_FFFF;
            desborde_d = 1'b1;
          end else begin
            monto_d = prod[31:0];
          end
        end else begin
          digito_d = acc_code;
          dstb_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      modo_q     <= MODO;
      digito_q   <= 4'd0;
      monto_q    <= 32'd0;
      desborde_q <= 1'b0;
      dstb_q     <= 1'b0;
      enter_q    <= 1'b0;
      erase_q    <= 1'b0;
      mstb_q     <= 1'b0;
    end else begin
      modo_q     <= MODO;
      digito_q   <= digito_d;
      monto_q    <= monto_d;
      desborde_q <= desborde_d;
      dstb_q     <= dstb_d;
      enter_q    <= enter_d;
      erase_q    <= erase_d;
      mstb_q     <= mstb_d;
    end
  end

  assign DIGITO     = digito_q;
  assign DIGITO_STB = dstb_q;
  assign ENTER_PIN  = enter_q;
  assign ERASE_PIN  = erase_q;
  assign MONTO      = monto_q;
  assign MONTO_STB  = mstb_q;
  assign DESBORDE   = desborde_q;

endmodule

// File: tb/tb_atm_keypad.sv
// Scoreboard bench for atm_keypad: stimulus pushes expected strobes, a monitor pops and compares them.
module tb_atm_keypad;

  localparam int DEB = 4;
  localparam int K_DIG = 0, K_ENT = 1, K_ERA = 2, K_MON = 3;

  logic        clk;
  logic        reset;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic        MODO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic        ENTER_PIN;
  logic        ERASE_PIN;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        DESBORDE;

  atm_keypad #(.DEB_CYC(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .MODO       (MODO),
    .DIGITO     (DIGITO),
    .DIGITO_STB (DIGITO_STB),
    .ENTER_PIN  (ENTER_PIN),
    .ERASE_PIN  (ERASE_PIN),
    .MONTO      (MONTO),
    .MONTO_STB  (MONTO_STB),
    .DESBORDE   (DESBORDE)
  );

  typedef struct {
    int          kind;
    logic [3:0]  dig;
    logic [31:0] mon;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // expected strobe lands DEB cycles after the next sampling edge plus an offset into the sequence
  task automatic expect_at(input int kind, input logic [3:0] d, input logic [31:0] m,
                           input logic o, input int off);
    exp_t e;
    e.kind = kind;
    e.dig  = d;
    e.mon  = m;
    e.ovf  = o;
    e.cyc  = cyc + 1 + off + DEB;
    q.push_back(e);
  endtask

  task automatic key_seq(input logic [3:0] code, input logic [15:0] pat, input int n,
                         input int rel, input int mode_at, input logic mode_val);
    for (int i = 0; i < n; i++) begin
      KEY_VALID = pat[i];
      KEY_CODE  = code;
      if (i == mode_at) MODO = mode_val;
      @(negedge clk);
    end
    KEY_VALID = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    key_seq(code, 16'hFFFF, 6, 6, -1, 1'b0);
  endtask

  always @(posedge clk) begin
    logic [3:0] stb;
    exp_t e;
    #1;
    stb = {MONTO_STB, ERASE_PIN, ENTER_PIN, DIGITO_STB};
    if (stb != 4'd0) begin
      chk("strobe_onehot", 64'($countones(stb)), 64'd1);
      if (q.size() == 0) begin
        chk("spurious_strobe", {60'd0, stb}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {60'd0, stb}, {60'd0, 4'(4'd1 << e.kind)});
        chk("strobe_latency", 64'(cyc), 64'(e.cyc));
        chk("DIGITO", {60'd0, DIGITO}, {60'd0, e.dig});
        chk("MONTO", {32'd0, MONTO}, {32'd0, e.mon});
        chk("DESBORDE", {63'd0, DESBORDE}, {63'd0, e.ovf});
      end
    end
  end

  logic [3:0]  dg[10];
  logic [31:0] mv[10];

  initial begin
    dg = '{4'd4, 4'd2, 4'd9, 4'd4, 4'd9, 4'd6, 4'd7, 4'd2, 4'd9, 4'd5};
    mv = '{32'd4, 32'd42, 32'd429, 32'd4294, 32'd42949, 32'd429496, 32'd4294967,
           32'd42949672, 32'd429496729, 32'd4294967295};

    reset = 1'b0; KEY_VALID = 1'b0; KEY_CODE = 4'd0; MODO = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_DIGITO", {60'd0, DIGITO}, 64'd0);
    chk("rst_MONTO", {32'd0, MONTO}, 64'd0);
    chk("rst_DESBORDE", {63'd0, DESBORDE}, 64'd0);
    chk("rst_strobes", {60'd0, MONTO_STB, ERASE_PIN, ENTER_PIN, DIGITO_STB}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // PIN mode: long hold, bounced press, short glitch
    expect_at(K_DIG, 4'd7, 32'd0, 1'b0, 0);
    key_seq(4'd7, 16'hFFFF, 10, 6, -1, 1'b0);
    chk("digito_hold7", {60'd0, DIGITO}, 64'd7);
    expect_at(K_DIG, 4'd3, 32'd0, 1'b0, 3);
    key_seq(4'd3, 16'h007B, 7, 6, -1, 1'b0);
    key_seq(4'd9, 16'h0007, 3, 6, -1, 1'b0);
    chk("glitch_digito", {60'd0, DIGITO}, 64'd3);
    expect_at(K_ERA, 4'd3, 32'd0, 1'b0, 0);
    press(4'hB);
    press(4'hE);
    expect_at(K_ENT, 4'd3, 32'd0, 1'b0, 0);
    press(4'hA);

    // amount mode accumulation and ENTER
    MODO = 1'b1;
    repeat (2) @(negedge clk);
    expect_at(K_MON, 4'd3, 32'd1, 1'b0, 0);    press(4'd1);
    expect_at(K_MON, 4'd3, 32'd12, 1'b0, 0);   press(4'd2);
    expect_at(K_MON, 4'd3, 32'd125, 1'b0, 0);  press(4'd5);
    expect_at(K_MON, 4'd3, 32'd1250, 1'b0, 0); press(4'd0);
    expect_at(K_ENT, 4'd3, 32'd1250, 1'b0, 0); press(4'hA);
    expect_at(K_MON, 4'd3, 32'd0, 1'b0, 0);    press(4'hB);

    // saturation boundary
    for (int i = 0; i < 10; i++) begin
      expect_at(K_MON, 4'd3, mv[i], 1'b0, 0);
      press(dg[i]);
    end
    expect_at(K_MON, 4'd3, 32'hFFFF_FFFF, 1'b1, 0); press(4'd0);
    expect_at(K_MON, 4'd3, 32'hFFFF_FFFF, 1'b1, 0); press(4'd3);
    expect_at(K_MON, 4'd3, 32'd0, 1'b0, 0);         press(4'hB);

    // mode change clears amount silently
    expect_at(K_MON, 4'd3, 32'd5, 1'b0, 0);  press(4'd5);
    expect_at(K_MON, 4'd3, 32'd55, 1'b0, 0); press(4'd5);
    MODO = 1'b0;
    repeat (3) @(negedge clk);
    chk("modechg_MONTO", {32'd0, MONTO}, 64'd0);
    chk("modechg_DESBORDE", {63'd0, DESBORDE}, 64'd0);

    // mode change in the very acceptance cycle: key acts in the new mode
    MODO = 1'b1;
    repeat (2) @(negedge clk);
    expect_at(K_MON, 4'd3, 32'd5, 1'b0, 0);  press(4'd5);
    expect_at(K_MON, 4'd3, 32'd55, 1'b0, 0); press(4'd5);
    expect_at(K_DIG, 4'd8, 32'd0, 1'b0, 0);
    key_seq(4'd8, 16'hFFFF, 6, 6, DEB, 1'b0);
    chk("samecyc_MONTO", {32'd0, MONTO}, 64'd0);

    // reset during DB_PRESS with the key held
    KEY_CODE = 4'd5; KEY_VALID = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_DIGITO", {60'd0, DIGITO}, 64'd0);
    reset = 1'b1;
    expect_at(K_DIG, 4'd5, 32'd0, 1'b0, 0);
    repeat (8) @(negedge clk);
    KEY_VALID = 1'b0;
    repeat (8) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
